// File: rtl/lif_pkg.sv
// Shared types for the LIF scheduler: FSM state encoding, default width and potential type.
// Build option LIF_SAT_ADD_EN (see lif_update_unit) selects a saturating membrane add.
package lif_pkg;

    localparam int LIF_Q = 32;

    typedef logic [LIF_Q-1:0] lif_pot_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EMIT,
        DONE
    } lif_sched_state_e;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky-integrate-and-fire update for one neuron: add, strict threshold compare, reset mux.
// Defining LIF_SAT_ADD_EN clamps the sum at all-ones on carry-out; otherwise the add wraps.
module lif_update_unit
    import lif_pkg::*;
#(
    parameter int Q = LIF_Q
) (
    input  logic [Q-1:0] v,
    input  logic [Q-1:0] in_data,
    input  logic [Q-1:0] threshold,
    output logic [Q-1:0] next_v,
    output logic         spike
);

    logic [Q-1:0] sum;

`ifdef LIF_SAT_ADD_EN
    logic [Q:0] wide_sum;

    assign wide_sum = {1'b0, v} + {1'b0, in_data};
    assign sum      = wide_sum[Q] ? '1 : wide_sum[Q-1:0];
`else
    assign sum = v + in_data;
`endif

    assign spike  = (sum > threshold);
    assign next_v = spike ? '0 : sum;

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexes one LIF update unit over N neurons for T steps, one spike vector per step.
// Honours build option LIF_SAT_ADD_EN through the instantiated lif_update_unit.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int T = 4,
    parameter int Q = LIF_Q,
    parameter int N = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [Q-1:0]                       threshold,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [Q-1:0]                       in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N-1:0]                       out_spikes,
    output logic [((T > 1) ? $clog2(T) : 1)-1:0] out_t,
    output logic                               busy,
    output logic                               done
);

    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    lif_sched_state_e state, next_state;

    logic [NW-1:0] n;
    logic [TW-1:0] t;
    logic [Q-1:0]  thr;
    logic [Q-1:0]  pot [N];
    logic [N-1:0]  spikes;

    logic [Q-1:0]  cur_v;
    logic [Q-1:0]  next_v;
    logic          spike;
    logic          last_n;
    logic          last_t;

    assign cur_v  = pot[n];
    assign last_n = (n == NW'(N - 1));
    assign last_t = (t == TW'(T - 1));

    lif_update_unit #(.Q(Q)) u_update (
        .v         (cur_v),
        .in_data   (in_data),
        .threshold (thr),
        .next_v    (next_v),
        .spike     (spike)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (in_valid && last_n) next_state = EMIT;
            EMIT: if (out_ready) next_state = last_t ? DONE : RUN;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake flags depend on the registered state only, never on inputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n      <= '0;
            t      <= '0;
            thr    <= '0;
            spikes <= '0;
            for (int i = 0; i < N; i++) pot[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        thr    <= threshold;
                        spikes <= '0;
                        n      <= '0;
                        t      <= '0;
                        for (int i = 0; i < N; i++) pot[i] <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        pot[n]    <= next_v;
                        spikes[n] <= spike;
                        n         <= last_n ? '0 : n + 1'b1;
                    end
                end
                EMIT: begin
                    // The final step keeps t so out_t still names it while DONE is shown.
                    if (out_ready && !last_t) begin
                        t      <= t + 1'b1;
                        n      <= '0;
                        spikes <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_spikes = spikes;
    assign out_t      = t;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler (N=4, T=4, Q=32) with a table, corner sequences and random runs.
// Expected saturating behaviour follows LIF_SAT_ADD_EN when that macro is defined for the build.
module tb_lif_scheduler;

    localparam int N = 4;
    localparam int T = 4;
    localparam int Q = 32;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [Q-1:0]  threshold;
    logic          in_valid;
    logic          in_ready;
    logic [Q-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_spikes;
    logic [1:0]    out_t;
    logic          busy;
    logic          done;

    int compared   = 0;
    int mismatched = 0;

    longint unsigned mv [N];
    logic [N-1:0]    obs [T];

    always #5 clk = ~clk;

    lif_scheduler #(.T(T), .Q(Q), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .threshold  (threshold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_spikes (out_spikes),
        .out_t      (out_t),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    // One time step of the reference neuron population, using plain integer arithmetic.
    function automatic logic [N-1:0] modelStep(input logic [Q-1:0] thr, input logic [Q-1:0] x [N]);
        logic [N-1:0] s;
        longint unsigned sum;
        s = '0;
        for (int i = 0; i < N; i++) begin
            sum = mv[i] + longint'(x[i]);
            if (sum >= MOD) begin
`ifdef LIF_SAT_ADD_EN
                sum = MOD - 1;
`else
                sum = sum - MOD;
`endif
            end
            s[i]  = (sum > longint'(thr));
            mv[i] = s[i] ? 0 : sum;
        end
        return s;
    endfunction

    // Runs one full inference; gaps insert idle in_valid cycles (with stray starts), holds stall out_ready.
    task automatic applyStimulus(input logic [Q-1:0] thr, input logic [Q-1:0] cur [T][N],
                                 input int gap_pct, input int min_hold, input int max_hold);
        logic [N-1:0] exp_spk;
        logic [N-1:0] held;
        logic [Q-1:0] step_in [N];
        int hold;
        int gaps;
        for (int i = 0; i < N; i++) mv[i] = 0;
        @(negedge clk);
        start     = 1'b1;
        threshold = thr;
        @(negedge clk);
        start     = 1'b0;
        threshold = $urandom;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        for (int t = 0; t < T; t++) begin
            for (int n = 0; n < N; n++) begin
                gaps = 0;
                while (gaps < 3 && $urandom_range(0, 99) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = $urandom;
                    start    = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    start = 1'b0;
                    checkOutput("in_ready_stall", 64'(in_ready), 64'd1);
                    gaps++;
                end
                in_valid = 1'b1;
                in_data  = cur[t][n];
                checkOutput("in_ready_run", 64'(in_ready), 64'd1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            for (int i = 0; i < N; i++) step_in[i] = cur[t][i];
            exp_spk = modelStep(thr, step_in);
            checkOutput("out_valid_rise", 64'(out_valid), 64'd1);
            checkOutput("in_ready_emit", 64'(in_ready), 64'd0);
            held = out_spikes;
            hold = $urandom_range(min_hold, max_hold);
            for (int h = 0; h < hold; h++) begin
                in_valid  = 1'b1;
                in_data   = $urandom;
                out_ready = 1'b0;
                @(negedge clk);
                checkOutput("out_valid_hold", 64'(out_valid), 64'd1);
                checkOutput("spikes_hold", 64'(out_spikes), 64'(held));
                checkOutput("in_ready_hold", 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            checkOutput("out_spikes", 64'(out_spikes), 64'(exp_spk));
            checkOutput("out_t", 64'(out_t), 64'(t));
            for (int i = 0; i < N; i++) checkOutput("potential", 64'(dut.pot[i]), 64'(mv[i]));
            obs[t] = out_spikes;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (t < T - 1) begin
                checkOutput("in_ready_next_step", 64'(in_ready), 64'd1);
                checkOutput("done_early", 64'(done), 64'd0);
            end else begin
                checkOutput("done_pulse", 64'(done), 64'd1);
                checkOutput("busy_in_done", 64'(busy), 64'd1);
                @(negedge clk);
                checkOutput("done_cleared", 64'(done), 64'd0);
                checkOutput("busy_cleared", 64'(busy), 64'd0);
            end
        end
    endtask

    typedef struct {
        logic [Q-1:0]   thr;
        logic [Q-1:0]   val;
        logic [4*N-1:0] exp;
    } vec_t;

    initial begin
        vec_t         vectors [5];
        logic [Q-1:0] cur [T][N];
        logic [Q-1:0] rthr;

        rst_n     = 1'b0;
        start     = 1'b0;
        threshold = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_out_spikes", 64'(out_spikes), 64'd0);
        checkOutput("reset_out_t", 64'(out_t), 64'd0);
        rst_n = 1'b1;

        // exp nibble t holds the spike vector of step t.
        vectors[0] = '{thr: 32'd10, val: 32'd3,  exp: 16'hF000};
        vectors[1] = '{thr: 32'd10, val: 32'd11, exp: 16'hFFFF};
        vectors[2] = '{thr: 32'd0,  val: 32'd0,  exp: 16'h0000};
        vectors[3] = '{thr: 32'd0,  val: 32'd1,  exp: 16'hFFFF};
        vectors[4] = '{thr: 32'd10, val: 32'd5,  exp: 16'h0F00};
        for (int r = 0; r < 5; r++) begin
            for (int t = 0; t < T; t++)
                for (int n = 0; n < N; n++) cur[t][n] = vectors[r].val;
            applyStimulus(vectors[r].thr, cur, 0, (r == 0) ? 5 : 0, (r == 0) ? 5 : 0);
            for (int t = 0; t < T; t++)
                checkOutput("table_spikes", 64'(obs[t]), 64'(vectors[r].exp[4*t +: 4]));
        end

        // Neuron 0 reaches exactly the threshold at t=1 and must not fire.
        for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++) cur[t][n] = '0;
        cur[0][0] = 32'd5;
        cur[1][0] = 32'd5;
        applyStimulus(32'd10, cur, 0, 0, 0);
        checkOutput("equal_threshold_t1", 64'(obs[1]), 64'd0);

        // Carry-out on neuron 0 at t=1: wraps to 0x10 or saturates to all-ones.
        for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++) cur[t][n] = '0;
        cur[0][0] = 32'hFFFF_FFF0;
        cur[1][0] = 32'h0000_0020;
        applyStimulus(32'hFFFF_FFF8, cur, 0, 0, 0);
`ifdef LIF_SAT_ADD_EN
        checkOutput("carry_t1", 64'(obs[1]), 64'd1);
`else
        checkOutput("carry_t1", 64'(obs[1]), 64'd0);
`endif

        // Reset in the middle of step 1 discards the inference.
        @(negedge clk);
        start     = 1'b1;
        threshold = 32'd10;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < N; n++) begin
            in_valid = 1'b1;
            in_data  = 32'd3;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("midrun_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            in_valid = 1'b1;
            in_data  = 32'd3;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("after_reset_busy", 64'(busy), 64'd0);
        checkOutput("after_reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("after_reset_out_t", 64'(out_t), 64'd0);
        for (int t = 0; t < T; t++)
            for (int n = 0; n < N; n++) cur[t][n] = 32'd3;
        applyStimulus(32'd10, cur, 0, 0, 0);
        for (int t = 0; t < T; t++)
            checkOutput("rerun_spikes", 64'(obs[t]), 64'(vectors[0].exp[4*t +: 4]));

        // Randomised inferences with stalls; the model supplies every expectation.
        for (int k = 0; k < 8; k++) begin
            rthr = (k % 3 == 2) ? $urandom : 32'($urandom_range(5, 40));
            for (int t = 0; t < T; t++)
                for (int n = 0; n < N; n++)
                    cur[t][n] = (k % 3 == 2) ? $urandom : 32'($urandom_range(0, 20));
            applyStimulus(rthr, cur, 30, 0, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

- Time-multiplexes one leaky-integrate-and-fire update datapath across `N` neurons over `T` time steps.
- Holds the membrane potentials of all `N` neurons in an internal register file.
- Consumes one input current per neuron per time step over a valid/ready stream.
- Emits one `N`-bit spike vector per time step; sits between the synaptic accumulation stage and the spike buffer of the SNN layer.

## Interface
- `T`, 4: time steps per inference.
- `Q`, 32: membrane/current width in bits, unsigned.
- `N`, 16: neurons served by the scheduler.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins an inference; ignored unless `busy`=0.
- `threshold` in Q: firing threshold, sampled on accepted `start`.
- `in_valid` in 1: input current valid.
- `in_ready` out 1: scheduler accepts input.
- `in_data` in Q: current for the neuron currently being updated.
- `out_valid` out 1: spike vector valid.
- `out_ready` in 1: downstream accepts spike vector.
- `out_spikes` out N: bit n is the spike of neuron n for step `out_t`.
- `out_t` out max(1,$clog2(T)): time step of `out_spikes`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last spike vector handshake.

## Operation
- FSM states: IDLE, RUN, EMIT, DONE.
- IDLE, on `start`:
  - latch `threshold`;
  - clear all N potentials and the spike vector to 0;
  - set n=0, t=0;
  - go to RUN.
- RUN:
  - `in_ready`=1; input order is neuron 0..N-1 within step t.
  - Each handshake computes sum = v[n] + `in_data` (Q-bit wrap).
  - spike = sum > threshold (strict compare).
  - v[n] <= spike ? 0 : sum; spikes[n] <= spike; n++.
  - The handshake with n=N-1 moves the FSM to EMIT.
- EMIT:
  - `out_valid`=1, `in_ready`=0.
  - `out_spikes` and `out_t` hold stable until `out_ready`.
  - On handshake with t<T-1: t++, n=0, spike vector cleared, back to RUN.
  - On handshake with t=T-1: go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Potentials persist across steps within one inference only.

## Timing
- Reset values:
  - state IDLE; n, t, all potentials, stored threshold and spike vector 0;
  - `in_ready`, `out_valid`, `busy`, `done` 0; `out_spikes` 0; `out_t` 0.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from inputs.
- Throughput in RUN is 1 input/cycle.
- `out_valid` rises the cycle after the N-th input handshake.
- Minimum step latency is N+1 cycles; minimum inference length is T·(N+1)+2 cycles from `start` to `done`.
- `start` while `busy` is ignored; `threshold` changes mid-inference have no effect.
- `in_valid` low in RUN stalls with no state change; `out_ready` low in EMIT stalls with outputs held.
- `rst_n` low in any state takes effect at the next edge: all registers return to reset values and any partial step is discarded.
- `busy` is 1 in RUN, EMIT and DONE.

## Configuration
- `LIF_SAT_ADD_EN`:
  - Defined: sum saturates at 2^Q−1 on carry-out.
  - Undefined: sum wraps modulo 2^Q.
  - Compare and reset rules are identical in both cases.

## Structure
- Package `lif_pkg` holds:
  - the FSM state enum `lif_sched_state_e`;
  - the default width constant `LIF_Q`;
  - the typedef `lif_pot_t` (logic [LIF_Q-1:0]).
- Sub-module `lif_update_unit` is purely combinational: inputs v, in_data, threshold; outputs next_v and spike. It contains the add with optional saturation, the compare and the reset mux, and is instantiated once.
- The scheduler owns the FSM, the counters, the potential register file and both handshakes.

## Test plan
All scenarios use N=4, T=4, Q=32.
- Inputs all 3, threshold 10 → spike vectors 0000, 0000, 0000, 1111 with out_t 0..3; `done` pulses once.
- Inputs all 11, threshold 10 → 1111 each step; potentials read 0 after each step.
- Neuron 0 inputs 5, 5, threshold 10 → no spike at t=1 (10 is not > 10); other neurons fed 0.
- `out_ready` held low 5 cycles in EMIT → `out_valid` stays 1, `out_spikes` stable, `in_ready` 0, stray `in_valid` ignored.
- Threshold 0xFFFFFFF8, neuron 0 inputs 0xFFFFFFF0 then 0x20:
  - without `LIF_SAT_ADD_EN`, sum 0x10 gives no spike at t=1;
  - with it, sum 0xFFFFFFFF gives a spike at t=1 and v resets to 0.
- `rst_n` low for one cycle mid-RUN at t=1 → next cycle `busy`=0 and `out_valid`=0; a new `start` with inputs all 3 reproduces scenario 1 exactly.
